// File: rtl/uart_intf_pkg.sv
// Shared constants for the UART command stage: default widths and FSM state encoding.
package uart_intf_pkg;

  localparam int unsigned DBIT_DEF = 8;
  localparam int unsigned OP_W_DEF = 6;

  localparam logic [2:0] GET_A  = 3'd0;
  localparam logic [2:0] GET_B  = 3'd1;
  localparam logic [2:0] GET_OP = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] SEND   = 3'd4;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Idle-cycle counter with synchronous clear; tc_o pulses on the TO_CYCLES-th enabled cycle.
module uart_timeout_cnt #(
  parameter int unsigned TO_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TO_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TO_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tc_o = en_i && (count_q == CntLast);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_alu_intf.sv
// Pops a 3-byte frame (A, B, opcode) from the RX FIFO, drives an external ALU, pushes the result.
// Optional frame timeout enabled by defining UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf
  import uart_intf_pkg::*;
#(
  parameter int unsigned DBIT      = DBIT_DEF,
  parameter int unsigned OP_W      = OP_W_DEF,
  parameter int unsigned TO_CYCLES = 1_000_000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_empty,
  input  logic [DBIT-1:0] i_rx_data,
  output logic            o_rd_uart,
  input  logic            i_tx_full,
  output logic            o_wr_uart,
  output logic [DBIT-1:0] o_w_data,
  output logic [DBIT-1:0] o_alu_a,
  output logic [DBIT-1:0] o_alu_b,
  output logic [OP_W-1:0] o_alu_op,
  input  logic [DBIT-1:0] i_alu_result,
  output logic            o_busy,
  output logic            o_frame_err
);

  logic [2:0]      state_q, state_d;
  logic [DBIT-1:0] a_q, a_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [DBIT-1:0] result_q, result_d;
  logic            frame_err_q, frame_err_d;
  logic            pop, push, to_tc;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    frame_err_d = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      GET_A: begin
        if (!i_rx_empty) begin
          pop     = 1'b1;
          a_d     = i_rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (!i_rx_empty) begin
          pop     = 1'b1;
          b_d     = i_rx_data;
          state_d = GET_OP;
        end else if (to_tc) begin
          frame_err_d = 1'b1;
          state_d     = GET_A;
        end
      end
      GET_OP: begin
        if (!i_rx_empty) begin
          pop     = 1'b1;
          op_d    = i_rx_data[OP_W-1:0];
          state_d = EXEC;
        end else if (to_tc) begin
          frame_err_d = 1'b1;
          state_d     = GET_A;
        end
      end
      EXEC: begin
        result_d = i_alu_result;
        state_d  = SEND;
      end
      SEND: begin
        if (!i_tx_full) begin
          push    = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_ALU_INTF_TIMEOUT_EN
  logic in_mid;
  assign in_mid = (state_q == GET_B) || (state_q == GET_OP);

  uart_timeout_cnt #(
    .TO_CYCLES(TO_CYCLES)
  ) u_timeout_cnt (
    .clk_i (i_clk),
    .rst_ni(i_reset),
    .clr_i (pop || !in_mid),
    .en_i  (in_mid && i_rx_empty),
    .tc_o  (to_tc)
  );
`else
  logic unused_to_cycles;
  assign unused_to_cycles = ^TO_CYCLES;
  assign to_tc            = 1'b0;
`endif

  // Handshake strobes are combinational, so mask them while reset is held.
  assign o_rd_uart   = pop && i_reset;
  assign o_wr_uart   = push && i_reset;
  assign o_busy      = (state_q != GET_A) && i_reset;
  assign o_w_data    = result_q;
  assign o_alu_a     = a_q;
  assign o_alu_b     = b_q;
  assign o_alu_op    = op_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed bench for uart_alu_intf with a FWFT RX FIFO model and an add/subtract ALU model.
module tb_uart_alu_intf;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic       o_rd_uart;
  logic       i_tx_full;
  logic       o_wr_uart;
  logic [7:0] o_w_data;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       o_busy;
  logic       o_frame_err;

  uart_alu_intf #(
    .DBIT     (8),
    .OP_W     (6),
    .TO_CYCLES(16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_rx_empty  (i_rx_empty),
    .i_rx_data   (i_rx_data),
    .o_rd_uart   (o_rd_uart),
    .i_tx_full   (i_tx_full),
    .o_wr_uart   (o_wr_uart),
    .o_w_data    (o_w_data),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .i_alu_result(i_alu_result),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  // RX FIFO model (first-word-fall-through) and ALU model
  logic [7:0] fifo_mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       alu_sub = 1'b0;

  assign i_rx_empty   = (rd_ptr == wr_ptr);
  assign i_rx_data    = fifo_mem[rd_ptr[5:0]];
  assign i_alu_result = alu_sub ? (o_alu_a - o_alu_b) : (o_alu_a + o_alu_b);

  always @(posedge clk) if (o_rd_uart) rd_ptr <= rd_ptr + 1;

  // Monitor, sampled mid-cycle
  int         cyc = 0;
  int         pop_cnt = 0, push_cnt = 0, idle_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  int         last_pop_cyc = 0;
  logic [7:0] push_log [0:15];
  int         push_cyc [0:15];
  int         pop_at_push [0:15];
  int         idle_at_push [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_rd_uart) begin
      pop_cnt      = pop_cnt + 1;
      last_pop_cyc = cyc;
    end
    if (o_wr_uart) begin
      push_log[push_cnt]     = o_w_data;
      push_cyc[push_cnt]     = cyc;
      pop_at_push[push_cnt]  = pop_cnt;
      idle_at_push[push_cnt] = idle_cnt;
      push_cnt               = push_cnt + 1;
    end
    if (!o_busy && i_reset) idle_cnt = idle_cnt + 1;
    if (o_frame_err) ferr_cnt = ferr_cnt + 1;
    if (o_rd_uart && o_wr_uart) both_cnt = both_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    load(a);
    load(b);
    load(c);
  endtask

  task automatic wait_push(input string tag, input int target, input int budget);
    int n = 0;
    while (push_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, push_cnt, target);
  endtask

  task automatic wait_pops(input string tag, input int target, input int budget);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, pop_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_reset   = 1'b0;
    i_tx_full = 1'b0;
    step(3);
    check("rst_rd", o_rd_uart, 0);
    check("rst_wr", o_wr_uart, 0);
    check("rst_busy", o_busy, 0);
    check("rst_a", o_alu_a, 0);
    check("rst_b", o_alu_b, 0);
    check("rst_op", o_alu_op, 0);
    check("rst_wdata", o_w_data, 0);
    check("rst_ferr", o_frame_err, 0);
    i_reset = 1'b1;
    step(2);

    // Frame 1: 5 + 3
    load3(8'h05, 8'h03, 8'h20);
    wait_push("f1_push", 1, 40);
    check("f1_data", push_log[0], 8'h08);
    check("f1_a", o_alu_a, 8'h05);
    check("f1_b", o_alu_b, 8'h03);
    check("f1_op", o_alu_op, 6'h20);
    check("f1_pops", pop_cnt, 3);
    check("f1_latency", push_cyc[0] - last_pop_cyc, 2);
    step(5);
    check("f1_single", push_cnt, 1);

    // Frame 2: 0x0A - 0x02, opcode upper bits dropped
    alu_sub = 1'b1;
    load3(8'h0A, 8'h02, 8'hFF);
    wait_push("f2_push", 2, 40);
    check("f2_op", o_alu_op, 6'h3F);
    check("f2_data", push_log[1], 8'h08);
    check("f2_pops", pop_cnt, 6);

    // Frame 3: TX back-pressure for 20+ cycles in SEND
    alu_sub   = 1'b0;
    i_tx_full = 1'b1;
    load3(8'h10, 8'h20, 8'h01);
    step(25);
    check("bp_nopush", push_cnt, 2);
    check("bp_wr", o_wr_uart, 0);
    check("bp_busy", o_busy, 1);
    check("bp_hold", o_w_data, 8'h30);
    check("bp_pops", pop_cnt, 9);
    i_tx_full = 1'b0;
    #1;
    check("bp_release_wr", o_wr_uart, 1);
    step(4);
    check("bp_one_push", push_cnt, 3);
    check("bp_data", push_log[2], 8'h30);

    // Frames 4/5 back-to-back
    load3(8'h01, 8'h02, 8'h00);
    load3(8'h03, 8'h04, 8'h00);
    wait_push("b2b_push", 5, 80);
    check("b2b_data0", push_log[3], 8'h03);
    check("b2b_data1", push_log[4], 8'h07);
    check("b2b_pops0", pop_at_push[3], 12);
    check("b2b_pops1", pop_at_push[4], 15);
    check("b2b_idle", idle_at_push[4] - idle_at_push[3], 1);

    // Reset mid-frame after two pops
    load(8'h11);
    load(8'h22);
    wait_pops("mid_pops", 17, 20);
    i_reset = 1'b0;
    step(1);
    load3(8'h01, 8'h01, 8'h20);
    #1;
    check("mrst_rd", o_rd_uart, 0);
    check("mrst_busy", o_busy, 0);
    check("mrst_a", o_alu_a, 0);
    check("mrst_b", o_alu_b, 0);
    check("mrst_wdata", o_w_data, 0);
    step(2);
    check("mrst_nopop", pop_cnt, 17);
    i_reset = 1'b1;
    wait_push("mrst_push", 6, 40);
    check("mrst_data", push_log[5], 8'h02);
    check("mrst_a_new", o_alu_a, 8'h01);
    check("mrst_pops", pop_cnt, 20);

    // Starve the frame after operand A
    load(8'h05);
    wait_pops("starve_pop", 21, 10);
    step(30);
    check("starve_a", o_alu_a, 8'h05);
`ifdef UART_ALU_INTF_TIMEOUT_EN
    check("to_ferr", ferr_cnt, 1);
    check("to_busy", o_busy, 0);
    load3(8'h02, 8'h03, 8'h20);
    wait_push("to_push", 7, 40);
    check("to_data", push_log[6], 8'h05);
`else
    check("noto_ferr", ferr_cnt, 0);
    check("noto_busy", o_busy, 1);
    load(8'h03);
    load(8'h20);
    wait_push("noto_push", 7, 40);
    check("noto_data", push_log[6], 8'h08);
`endif
    check("rd_wr_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
